branch_resolve_queue: RTL and testbench

In-order queue of in-flight conditional branches, placed between the fetch-stage direction predictor and the execute stage. Fetch pushes one entry per predicted branch; execute resolves branches oldest-first. The block then drives the predictor update strobe (valid, predicted direction, actual outcome) and, on a mispredict, a registered flush and redirect PC back to fetch.

---
 rtl/branch_resolve_queue_pkg.sv | 31 +++
 rtl/branch_fifo.sv | 68 ++++++
 rtl/branch_resolve_queue.sv | 116 +++++++++++
 tb/tb_branch_resolve_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_queue_pkg
//  Description : Shared branch-queue constants: address/predictor-ID widths,
//                default queue depth and the packed entry layout
//                {pred, pred_id, alt_pc}, alt_pc in the low bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_queue_pkg;

  localparam int BRQ_W_ADDR = 32;
  localparam int BRQ_W_BRID = 2;
  localparam int BRQ_DEPTH  = 4;

  // Entry field layout as a function of the widths in use.
  localparam int ENT_ALT_LSB = 0;

  function automatic int ent_id_lsb(input int w_addr);
    return w_addr;
  endfunction

  function automatic int ent_pred_bit(input int w_addr, input int w_brid);
    return w_addr + w_brid;
  endfunction

  function automatic int ent_width(input int w_addr, input int w_brid);
    return w_addr + w_brid + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : branch_fifo
//  Description : Generic DEPTH x WIDTH register FIFO with clear, wrapping
//                pointers and a separate occupancy counter. The head entry is
//                presented combinationally on rdata.
//  Ports       : clk, reset (async active-low), clear, push, pop, wdata,
//                rdata (head entry), count (occupied entries)
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Guard against overflow/underflow so the counter can never leave 0..DEPTH.
  assign w_push = push & (r_count != C_DEPTH);
  assign w_pop  = pop  & (r_count != '0);

  // Storage carries no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem[r_tail] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  assign rdata = r_mem[r_head];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_queue
//  Description : In-order queue of in-flight conditional branches between the
//                fetch-stage predictor and execute. Resolves oldest-first,
//                emits a one-cycle predictor update per resolve and, on a
//                mispredict, a registered flush with redirect PC.
//  Ports       : enq_*   - push from fetch (enq_rdy_o combinational)
//                res_*   - resolve of the oldest branch from execute
//                upd_*   - registered predictor update strobe and data
//                flush_o / redirect_pc_o - registered mispredict restart
//                count_o - occupancy, err_o - sticky resolve-while-empty
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int W_ADDR = BRQ_W_ADDR,
  parameter int W_BRID = BRQ_W_BRID,
  parameter int DEPTH  = BRQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_v_i,
  input  logic                   enq_pred_i,
  input  logic [W_BRID-1:0]      enq_pred_id_i,
  input  logic [W_ADDR-1:0]      enq_alt_pc_i,
  output logic                   enq_rdy_o,
  input  logic                   res_v_i,
  input  logic                   res_taken_i,
  input  logic [W_ADDR-1:0]      res_target_i,
  output logic                   upd_v_o,
  output logic                   upd_table_o,
  output logic                   upd_branch_o,
  output logic [W_BRID-1:0]      upd_pred_id_o,
  output logic                   flush_o,
  output logic [W_ADDR-1:0]      redirect_pc_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   err_o
);

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int ENT_W   = ent_width(W_ADDR, W_BRID);
  localparam int ID_LSB  = ent_id_lsb(W_ADDR);
  localparam int PRED_B  = ent_pred_bit(W_ADDR, W_BRID);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [ENT_W-1:0]  w_head;
  logic [ENT_W-1:0]  w_wdata;
  logic [CW-1:0]     w_count;
  logic              w_push;
  logic              w_res;
  logic              w_mis;
  logic              w_head_pred;
  logic [W_BRID-1:0] w_head_id;
  logic [W_ADDR-1:0] w_head_alt;

  assign w_wdata     = {enq_pred_i, enq_pred_id_i, enq_alt_pc_i};
  assign w_head_pred = w_head[PRED_B];
  assign w_head_id   = w_head[ID_LSB +: W_BRID];
  assign w_head_alt  = w_head[ENT_ALT_LSB +: W_ADDR];

  // Ready depends only on the registered count: a same-cycle pop never frees
  // a slot for the push in that cycle.
  assign enq_rdy_o = (w_count < C_DEPTH);
  assign w_push    = enq_v_i & enq_rdy_o;
  assign w_res     = res_v_i & (w_count != '0);
  assign w_mis     = w_res & (w_head_pred ^ res_taken_i);

  // A mispredict clears the whole queue; any push in that cycle is on the
  // wrong path and is dropped along with it.
  branch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (w_mis),
    .push  (w_push & ~w_mis),
    .pop   (w_res & ~w_mis),
    .wdata (w_wdata),
    .rdata (w_head),
    .count (w_count)
  );

  assign count_o = w_count;

  // Strobes pulse for one cycle; data outputs keep their last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_v_o       <= 1'b0;
      upd_table_o   <= 1'b0;
      upd_branch_o  <= 1'b0;
      upd_pred_id_o <= '0;
      flush_o       <= 1'b0;
      redirect_pc_o <= '0;
      err_o         <= 1'b0;
    end else begin
      upd_v_o <= w_res;
      flush_o <= w_mis;
      if (w_res) begin
        upd_table_o   <= w_head_pred;
        upd_branch_o  <= res_taken_i;
        upd_pred_id_o <= w_head_id;
      end
      if (w_mis) begin
        redirect_pc_o <= res_taken_i ? res_target_i : w_head_alt;
      end
      if (res_v_i && (w_count == '0)) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_queue
//  Description : Self-checking bench for branch_resolve_queue (DEPTH = 4):
//                a directed vector table applied one cycle per entry, then a
//                hand-written asynchronous-reset-mid-burst sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        enq_v_i, enq_pred_i;
  logic [1:0]  enq_pred_id_i;
  logic [31:0] enq_alt_pc_i;
  logic        enq_rdy_o;
  logic        res_v_i, res_taken_i;
  logic [31:0] res_target_i;
  logic        upd_v_o, upd_table_o, upd_branch_o;
  logic [1:0]  upd_pred_id_o;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic [2:0]  count_o;
  logic        err_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_resolve_queue #(.W_ADDR(32), .W_BRID(2), .DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .enq_v_i       (enq_v_i),
    .enq_pred_i    (enq_pred_i),
    .enq_pred_id_i (enq_pred_id_i),
    .enq_alt_pc_i  (enq_alt_pc_i),
    .enq_rdy_o     (enq_rdy_o),
    .res_v_i       (res_v_i),
    .res_taken_i   (res_taken_i),
    .res_target_i  (res_target_i),
    .upd_v_o       (upd_v_o),
    .upd_table_o   (upd_table_o),
    .upd_branch_o  (upd_branch_o),
    .upd_pred_id_o (upd_pred_id_o),
    .flush_o       (flush_o),
    .redirect_pc_o (redirect_pc_o),
    .count_o       (count_o),
    .err_o         (err_o)
  );

  typedef struct {
    logic        ev, ep;
    logic [1:0]  eid;
    logic [31:0] ealt;
    logic        rv, rt;
    logic [31:0] rtgt;
    logic        xrdy, xupd, xtab, xbr;
    logic [1:0]  xid;
    logic        xfl;
    logic [31:0] xpc;
    logic [2:0]  xcnt;
    logic        xerr;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic ev, input logic ep, input logic [1:0] eid, input logic [31:0] ealt,
    input logic rv, input logic rt, input logic [31:0] rtgt,
    input logic xrdy, input logic xupd, input logic xtab, input logic xbr,
    input logic [1:0] xid, input logic xfl, input logic [31:0] xpc,
    input logic [2:0] xcnt, input logic xerr);
    vec_t v;
    v.ev = ev; v.ep = ep; v.eid = eid; v.ealt = ealt;
    v.rv = rv; v.rt = rt; v.rtgt = rtgt;
    v.xrdy = xrdy; v.xupd = xupd; v.xtab = xtab; v.xbr = xbr; v.xid = xid;
    v.xfl = xfl; v.xpc = xpc; v.xcnt = xcnt; v.xerr = xerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    enq_v_i = 0; enq_pred_i = 0; enq_pred_id_i = 0; enq_alt_pc_i = 0;
    res_v_i = 0; res_taken_i = 0; res_target_i = 0;
  endtask

  initial begin
    // Fields: push(v,pred,id,alt) resolve(v,taken,target) |
    //         expect rdy(pre-edge), upd_v,table,branch,id, flush,pc, count, err
    vecs[0]  = mk(1,1,2'd2,32'h104, 0,0,32'h0,   1, 0,0,0,2'd0, 0,32'h0,   3'd1, 0);
    vecs[1]  = mk(0,0,2'd0,32'h0,   1,1,32'h200, 1, 1,1,1,2'd2, 0,32'h0,   3'd0, 0);
    vecs[2]  = mk(1,1,2'd1,32'h104, 0,0,32'h0,   1, 0,0,0,2'd0, 0,32'h0,   3'd1, 0);
    vecs[3]  = mk(0,0,2'd0,32'h0,   1,0,32'h0,   1, 1,1,0,2'd1, 1,32'h104, 3'd0, 0);
    vecs[4]  = mk(1,0,2'd0,32'h110, 0,0,32'h0,   1, 0,0,0,2'd0, 0,32'h0,   3'd1, 0);
    vecs[5]  = mk(1,0,2'd1,32'h114, 0,0,32'h0,   1, 0,0,0,2'd0, 0,32'h0,   3'd2, 0);
    vecs[6]  = mk(1,0,2'd2,32'h118, 0,0,32'h0,   1, 0,0,0,2'd0, 0,32'h0,   3'd3, 0);
    vecs[7]  = mk(1,0,2'd3,32'h11c, 1,1,32'h300, 1, 1,0,1,2'd0, 1,32'h300, 3'd0, 0);
    vecs[8]  = mk(0,0,2'd0,32'h0,   0,0,32'h0,   1, 0,0,0,2'd0, 0,32'h0,   3'd0, 0);
    vecs[9]  = mk(1,1,2'd0,32'h400, 0,0,32'h0,   1, 0,0,0,2'd0, 0,32'h0,   3'd1, 0);
    vecs[10] = mk(1,1,2'd1,32'h404, 0,0,32'h0,   1, 0,0,0,2'd0, 0,32'h0,   3'd2, 0);
    vecs[11] = mk(1,1,2'd2,32'h408, 0,0,32'h0,   1, 0,0,0,2'd0, 0,32'h0,   3'd3, 0);
    vecs[12] = mk(1,1,2'd3,32'h40c, 0,0,32'h0,   1, 0,0,0,2'd0, 0,32'h0,   3'd4, 0);
    vecs[13] = mk(1,1,2'd0,32'h410, 0,0,32'h0,   0, 0,0,0,2'd0, 0,32'h0,   3'd4, 0);
    vecs[14] = mk(1,1,2'd0,32'h414, 1,1,32'h500, 0, 1,1,1,2'd0, 0,32'h0,   3'd3, 0);
    // Eight pushes interleaved with correct resolves; ids leave in push order.
    vecs[15] = mk(1,1,2'd0,32'h600, 1,1,32'h0,   1, 1,1,1,2'd1, 0,32'h0,   3'd3, 0);
    vecs[16] = mk(1,1,2'd1,32'h604, 1,1,32'h0,   1, 1,1,1,2'd2, 0,32'h0,   3'd3, 0);
    vecs[17] = mk(1,1,2'd2,32'h608, 1,1,32'h0,   1, 1,1,1,2'd3, 0,32'h0,   3'd3, 0);
    vecs[18] = mk(1,1,2'd3,32'h60c, 1,1,32'h0,   1, 1,1,1,2'd0, 0,32'h0,   3'd3, 0);
    vecs[19] = mk(1,1,2'd0,32'h610, 1,1,32'h0,   1, 1,1,1,2'd1, 0,32'h0,   3'd3, 0);
    vecs[20] = mk(1,1,2'd1,32'h614, 1,1,32'h0,   1, 1,1,1,2'd2, 0,32'h0,   3'd3, 0);
    vecs[21] = mk(1,1,2'd2,32'h618, 1,1,32'h0,   1, 1,1,1,2'd3, 0,32'h0,   3'd3, 0);
    vecs[22] = mk(1,1,2'd3,32'h61c, 1,1,32'h0,   1, 1,1,1,2'd0, 0,32'h0,   3'd3, 0);
    vecs[23] = mk(0,0,2'd0,32'h0,   1,1,32'h0,   1, 1,1,1,2'd1, 0,32'h0,   3'd2, 0);
    vecs[24] = mk(0,0,2'd0,32'h0,   1,1,32'h0,   1, 1,1,1,2'd2, 0,32'h0,   3'd1, 0);
    vecs[25] = mk(0,0,2'd0,32'h0,   1,1,32'h0,   1, 1,1,1,2'd3, 0,32'h0,   3'd0, 0);
    vecs[26] = mk(1,0,2'd2,32'h500, 0,0,32'h0,   1, 0,0,0,2'd0, 0,32'h0,   3'd1, 0);
    vecs[27] = mk(0,0,2'd0,32'h0,   1,0,32'h0,   1, 1,0,0,2'd2, 0,32'h0,   3'd0, 0);
    // Resolve while empty: no update, sticky error.
    vecs[28] = mk(0,0,2'd0,32'h0,   1,1,32'h700, 1, 0,0,0,2'd0, 0,32'h0,   3'd0, 1);
    vecs[29] = mk(0,0,2'd0,32'h0,   0,0,32'h0,   1, 0,0,0,2'd0, 0,32'h0,   3'd0, 1);

    idle_inputs();
    reset = 1'b0;
    #12;
    chk("reset_upd_v", 32'(upd_v_o), 32'd0);
    chk("reset_outputs", {upd_table_o, upd_branch_o, upd_pred_id_o, flush_o, err_o}, 32'd0);
    chk("reset_redirect", redirect_pc_o, 32'd0);
    chk("reset_count", 32'(count_o), 32'd0);
    chk("reset_rdy", 32'(enq_rdy_o), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      logic bad;
      enq_v_i = vecs[i].ev; enq_pred_i = vecs[i].ep;
      enq_pred_id_i = vecs[i].eid; enq_alt_pc_i = vecs[i].ealt;
      res_v_i = vecs[i].rv; res_taken_i = vecs[i].rt; res_target_i = vecs[i].rtgt;
      #1;
      bad = (enq_rdy_o !== vecs[i].xrdy);
      @(posedge clk);
      #1;
      bad = bad | (upd_v_o !== vecs[i].xupd) | (flush_o !== vecs[i].xfl)
                | (count_o !== vecs[i].xcnt) | (err_o !== vecs[i].xerr);
      if (vecs[i].xupd)
        bad = bad | (upd_table_o !== vecs[i].xtab) | (upd_branch_o !== vecs[i].xbr)
                  | (upd_pred_id_o !== vecs[i].xid);
      if (vecs[i].xfl)
        bad = bad | (redirect_pc_o !== vecs[i].xpc);
      n_vec++;
      if (bad) begin
        n_bad++;
        $display("FAIL vec%0d: got rdy=%b upd=%b tab=%b br=%b id=%0d fl=%b pc=0x%0h cnt=%0d err=%b, expected rdy=%b upd=%b tab=%b br=%b id=%0d fl=%b pc=0x%0h cnt=%0d err=%b",
                 i, enq_rdy_o, upd_v_o, upd_table_o, upd_branch_o, upd_pred_id_o, flush_o,
                 redirect_pc_o, count_o, err_o, vecs[i].xrdy, vecs[i].xupd, vecs[i].xtab,
                 vecs[i].xbr, vecs[i].xid, vecs[i].xfl, vecs[i].xpc, vecs[i].xcnt, vecs[i].xerr);
      end
    end

    // Reset asserted mid-burst: three entries queued, an update pulse live.
    idle_inputs();
    for (int k = 1; k <= 3; k++) begin
      enq_v_i = 1; enq_pred_i = 1; enq_pred_id_i = 2'(k); enq_alt_pc_i = 32'h800 + 32'(4 * k);
      @(posedge clk);
      #1;
    end
    chk("burst_count", 32'(count_o), 32'd3);
    enq_v_i = 0; res_v_i = 1; res_taken_i = 1; res_target_i = 32'h900;
    @(posedge clk);
    #1;
    chk("burst_upd_v", 32'(upd_v_o), 32'd1);
    chk("burst_upd_id", 32'(upd_pred_id_o), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_upd_v", 32'(upd_v_o), 32'd0);
    chk("async_outputs", {upd_table_o, upd_branch_o, upd_pred_id_o, flush_o, err_o}, 32'd0);
    chk("async_redirect", redirect_pc_o, 32'd0);
    chk("async_count", 32'(count_o), 32'd0);
    chk("async_rdy", 32'(enq_rdy_o), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    res_v_i = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("post_reset_upd_v", 32'(upd_v_o), 32'd0);
      chk("post_reset_count", 32'(count_o), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
